// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the carry-save accumulator.
//   state_t          : controller state encoding (IDLE/ACCUM/RESOLVE/DONE)
//   NUM_OPS_MIN/MAX  : legal range of operands per beat
//   EXT_MAX_WIDTH    : widest operand/accumulator the extension helper covers
//   extend_operand() : sign- or zero-extends an operand of a given width
//                      up to EXT_MAX_WIDTH bits
// ---------------------------------------------------------------------------
package csa_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int NUM_OPS_MIN   = 1;
   localparam int NUM_OPS_MAX   = 4;
   localparam int EXT_MAX_WIDTH = 64;

   // Bits of value above 'width' are ignored; they are refilled with zeros,
   // or with copies of bit width-1 when is_signed is set.
   function automatic logic [EXT_MAX_WIDTH-1:0] extend_operand(
      input logic [EXT_MAX_WIDTH-1:0] value,
      input int                       width,
      input logic                     is_signed
   );
      logic [EXT_MAX_WIDTH-1:0] mask;
      logic [EXT_MAX_WIDTH-1:0] result;
      mask = (width >= EXT_MAX_WIDTH) ? '1
                                      : ((EXT_MAX_WIDTH'(1) << width) - EXT_MAX_WIDTH'(1));
      result = value & mask;
      if (is_signed && (width > 0) && value[width-1]) begin
         result = result | ~mask;
      end
      return result;
   endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// ---------------------------------------------------------------------------
// csa_accumulator_if
// Beat input and result output handshakes of the carry-save accumulator.
//   in_valid/in_ready/in_data/in_last : operand beats (producer -> block)
//   out_valid/out_ready/out_sum       : resolved total (block -> consumer)
//   out_beats                         : beats in the reduction, present only
//                                       when CSA_ACC_BEATCOUNT_EN is defined
// Modports: master = producer/consumer side, slave = accumulator side.
// ---------------------------------------------------------------------------
interface csa_accumulator_if #(
   parameter int WIDTH     = 16,
   parameter int NUM_OPS   = 2,
   parameter int ACC_WIDTH = 24
);

   logic                       in_valid;
   logic                       in_ready;
   logic [NUM_OPS*WIDTH-1:0]   in_data;
   logic                       in_last;
   logic                       out_valid;
   logic                       out_ready;
   logic [ACC_WIDTH-1:0]       out_sum;
`ifdef CSA_ACC_BEATCOUNT_EN
   logic [15:0]                out_beats;
`endif

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum
`ifdef CSA_ACC_BEATCOUNT_EN
      ,
      input  out_beats
`endif
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum
`ifdef CSA_ACC_BEATCOUNT_EN
      ,
      output out_beats
`endif
   );

endinterface

// File: rtl/csa_compress_3to2.sv
// ---------------------------------------------------------------------------
// csa_compress_3to2
// Bitwise full-adder array reducing three W-bit vectors to a sum vector and
// a carry vector. The carry vector comes out already weighted (shifted left
// by one) with the top carry discarded, so s + cy == a + b + c mod 2^W.
//   a, b, c : addends
//   s       : bitwise sum
//   cy      : shifted carries, bit 0 always 0
// ---------------------------------------------------------------------------
module csa_compress_3to2 #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] cy
);

   assign s = a ^ b ^ c;

   // Majority of bit i becomes carry bit i+1; the majority of the MSB
   // would fall off the top, so it is never formed.
   assign cy[0]   = 1'b0;
   assign cy[W-1:1] = (a[W-2:0] & b[W-2:0]) |
                      (a[W-2:0] & c[W-2:0]) |
                      (b[W-2:0] & c[W-2:0]);

endmodule

// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
// Streaming multi-operand accumulator. Each accepted beat of NUM_OPS
// operands is folded into a redundant sum/carry state through a chain of
// 3:2 compressors; the last beat triggers one carry-propagate add whose
// result is offered on the output handshake.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : csa_accumulator_if slave (beat input, result output)
// Parameters: WIDTH (operand bits), NUM_OPS (1..4), ACC_WIDTH (state and
// result bits, >= WIDTH+1), SIGNED (1 = sign-extend operands).
// Optional: CSA_ACC_BEATCOUNT_EN adds bus.out_beats, a saturating count of
// beats accepted in the reduction.
// ---------------------------------------------------------------------------
module csa_accumulator #(
   parameter int WIDTH     = 16,
   parameter int NUM_OPS   = 2,
   parameter int ACC_WIDTH = 24,
   parameter int SIGNED    = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   csa_accumulator_if.slave   bus
);

   import csa_pkg::*;

   if ((NUM_OPS < NUM_OPS_MIN) || (NUM_OPS > NUM_OPS_MAX)) begin : g_bad_num_ops
      $error("csa_accumulator: NUM_OPS out of legal range");
   end

   state_t               state;
   state_t               next_state;
   logic                 in_ready_r;
   logic                 out_valid_r;
   logic [ACC_WIDTH-1:0] sum_r;
   logic [ACC_WIDTH-1:0] carry_r;
   logic [ACC_WIDTH-1:0] out_sum_r;
   logic                 accept;
   logic                 handshake;

   logic [ACC_WIDTH-1:0] op_ext    [0:NUM_OPS-1];
   logic [ACC_WIDTH-1:0] stage_sum [0:NUM_OPS];
   logic [ACC_WIDTH-1:0] stage_cy  [0:NUM_OPS];

   assign accept    = bus.in_valid && in_ready_r;
   assign handshake = out_valid_r && bus.out_ready;

   // A fresh reduction starts from zero regardless of the stored state.
   assign stage_sum[0] = (state == IDLE) ? '0 : sum_r;
   assign stage_cy[0]  = (state == IDLE) ? '0 : carry_r;

   // One compressor per operand; each stage folds one extended operand into
   // the running (sum, carry) pair within the same cycle.
   for (genvar k = 0; k < NUM_OPS; k++) begin : g_stage
      assign op_ext[k] = ACC_WIDTH'(extend_operand(
                            EXT_MAX_WIDTH'(bus.in_data[k*WIDTH +: WIDTH]),
                            WIDTH, SIGNED != 0));

      csa_compress_3to2 #(.W(ACC_WIDTH)) u_compress (
         .a  (stage_sum[k]),
         .b  (stage_cy[k]),
         .c  (op_ext[k]),
         .s  (stage_sum[k+1]),
         .cy (stage_cy[k+1])
      );
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: beats are taken in IDLE/ACCUM, the last one moves to
   // RESOLVE, and DONE waits for the consumer.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE, ACCUM: begin
            if (accept) begin
               next_state = bus.in_last ? RESOLVE : ACCUM;
            end
         end
         RESOLVE: next_state = DONE;
         DONE: begin
            if (handshake) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath and handshake registers. in_ready is registered from the next
   // state so it is low throughout reset, high one cycle after release, and
   // never combinationally tied to in_valid. The carry-propagate add is
   // captured in RESOLVE and published with out_valid on the first DONE edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         sum_r       <= '0;
         carry_r     <= '0;
         out_sum_r   <= '0;
      end else begin
         in_ready_r <= (next_state == IDLE) || (next_state == ACCUM);

         if (accept) begin
            sum_r   <= stage_sum[NUM_OPS];
            carry_r <= stage_cy[NUM_OPS];
         end else if (handshake) begin
            sum_r   <= '0;
            carry_r <= '0;
         end

         if (state == RESOLVE) begin
            out_sum_r <= sum_r + carry_r;
         end

         if (handshake) begin
            out_valid_r <= 1'b0;
         end else if (state == DONE) begin
            out_valid_r <= 1'b1;
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sum   = out_sum_r;

`ifdef CSA_ACC_BEATCOUNT_EN
   logic [15:0] beat_cnt;

   // Counts accepted beats, sticking at all-ones; cleared once the result
   // has been taken so the next reduction counts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
      end else if (accept) begin
         if (beat_cnt != 16'hFFFF) begin
            beat_cnt <= beat_cnt + 16'd1;
         end
      end else if (handshake) begin
         beat_cnt <= '0;
      end
   end

   assign bus.out_beats = beat_cnt;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
// Drives an unsigned and a signed csa_accumulator (WIDTH=16, NUM_OPS=2,
// ACC_WIDTH=24) with identical beats and compares both totals against
// hand-computed values, plus handshake timing and reset behaviour.
// Honours CSA_ACC_BEATCOUNT_EN for the beat-count output.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

   localparam int WIDTH     = 16;
   localparam int NUM_OPS   = 2;
   localparam int ACC_WIDTH = 24;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   csa_accumulator_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_WIDTH(ACC_WIDTH)) u_if ();
   csa_accumulator_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_WIDTH(ACC_WIDTH)) s_if ();

   csa_accumulator #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_WIDTH(ACC_WIDTH), .SIGNED(0)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   csa_accumulator #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_WIDTH(ACC_WIDTH), .SIGNED(1)) s_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (s_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        last;
      logic [23:0] exp_u;
      logic [23:0] exp_s;
      logic [15:0] exp_beats;
      int          stall;
   } vec_t;

   vec_t vecs [10];

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Presents one beat on both DUTs, starting just after a falling edge, and
   // returns at the falling edge following the accepting rising edge.
   task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic last);
      int guard = 0;
      u_if.in_valid = 1'b1;  u_if.in_data = {b, a};  u_if.in_last = last;
      s_if.in_valid = 1'b1;  s_if.in_data = {b, a};  s_if.in_last = last;
      while (!u_if.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check_output("beat_accept_timeout", 32'(guard), 32'd0);
      @(posedge clk);
      @(negedge clk);
      u_if.in_valid = 1'b0;  u_if.in_last = 1'b0;
      s_if.in_valid = 1'b0;  s_if.in_last = 1'b0;
   endtask

   // Called at the falling edge right after the last beat was accepted.
   // Expects out_valid two cycles after acceptance, optionally stalls the
   // consumer, then completes the handshake.
   task automatic collect_result(input string name, input logic [23:0] exp_u,
                                 input logic [23:0] exp_s, input logic [15:0] exp_beats,
                                 input int stall);
      int          cycles = 0;
      logic        busy_ready = 1'b0;
      logic        unstable = 1'b0;
      logic [23:0] held;
      u_if.out_ready = (stall == 0);
      s_if.out_ready = (stall == 0);
      busy_ready = u_if.in_ready;
      while (!u_if.out_valid && cycles < 20) begin
         @(negedge clk);
         cycles++;
         if (!u_if.out_valid && u_if.in_ready) busy_ready = 1'b1;
      end
      check_output({name, "_latency"}, 32'(cycles), 32'd2);
      check_output({name, "_sum_unsigned"}, 32'(u_if.out_sum), 32'(exp_u));
      check_output({name, "_sum_signed"}, 32'(s_if.out_sum), 32'(exp_s));
`ifdef CSA_ACC_BEATCOUNT_EN
      check_output({name, "_beats"}, 32'(u_if.out_beats), 32'(exp_beats));
`endif
      held = u_if.out_sum;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (!u_if.out_valid || (u_if.out_sum !== held)) unstable = 1'b1;
         if (u_if.in_ready) busy_ready = 1'b1;
      end
      if (stall > 0) check_output({name, "_stall_stable"}, 32'(unstable), 32'd0);
      check_output({name, "_ready_low_busy"}, 32'(busy_ready), 32'd0);
      u_if.out_ready = 1'b1;
      s_if.out_ready = 1'b1;
      @(negedge clk);
      check_output({name, "_valid_dropped"}, 32'(u_if.out_valid), 32'd0);
      check_output({name, "_ready_back"}, 32'(u_if.in_ready), 32'd1);
      u_if.out_ready = 1'b0;
      s_if.out_ready = 1'b0;
      $display("[TB] %s done (%0d beats expected)", name, exp_beats);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;

      //              a         b         last  exp_u        exp_s        beats stall
      vecs[0] = '{16'd3,    16'd5,    1'b1, 24'd8,       24'd8,       16'd1, 0};
      vecs[1] = '{16'd1,    16'd2,    1'b0, 24'd0,       24'd0,       16'd0, 0};
      vecs[2] = '{16'd3,    16'd4,    1'b0, 24'd0,       24'd0,       16'd0, 0};
      vecs[3] = '{16'd5,    16'd6,    1'b0, 24'd0,       24'd0,       16'd0, 0};
      vecs[4] = '{16'd7,    16'd8,    1'b1, 24'd36,      24'd36,      16'd4, 0};
      vecs[5] = '{16'hFFFF, 16'hFFFE, 1'b0, 24'd0,       24'd0,       16'd0, 0};
      vecs[6] = '{16'h0001, 16'h0000, 1'b1, 24'h01FFFE,  24'hFFFFFE,  16'd2, 5};
      vecs[7] = '{16'd2,    16'd2,    1'b1, 24'd4,       24'd4,       16'd1, 0};
      vecs[8] = '{16'h8000, 16'h8000, 1'b1, 24'h010000,  24'hFF0000,  16'd1, 0};
      vecs[9] = '{16'h7FFF, 16'h0001, 1'b1, 24'h008000,  24'h008000,  16'd1, 0};

      rst_n = 1'b0;
      u_if.in_valid = 1'b0;  u_if.in_data = '0;  u_if.in_last = 1'b0;  u_if.out_ready = 1'b0;
      s_if.in_valid = 1'b0;  s_if.in_data = '0;  s_if.in_last = 1'b0;  s_if.out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_output("reset_in_ready", 32'(u_if.in_ready), 32'd0);
      check_output("reset_out_valid", 32'(u_if.out_valid), 32'd0);
      check_output("reset_out_sum", 32'(u_if.out_sum), 32'd0);
      rst_n = 1'b1;
      #1;
      check_output("release_in_ready_low", 32'(u_if.in_ready), 32'd0);
      @(negedge clk);
      check_output("release_in_ready_high", 32'(u_if.in_ready), 32'd1);

      // Table-driven reductions
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].last);
         if (vecs[i].last) begin
            collect_result($sformatf("vec%0d", i), vecs[i].exp_u, vecs[i].exp_s,
                           vecs[i].exp_beats, vecs[i].stall);
         end
      end

      // in_last without in_valid must not end the reduction
      apply_stimulus(16'd10, 16'd20, 1'b0);
      u_if.in_last = 1'b1;
      s_if.in_last = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("lone_last_ready", 32'(u_if.in_ready), 32'd1);
      check_output("lone_last_valid", 32'(u_if.out_valid), 32'd0);
      u_if.in_last = 1'b0;
      s_if.in_last = 1'b0;
      apply_stimulus(16'd1, 16'd1, 1'b1);
      collect_result("lone_last", 24'd32, 24'd32, 16'd2, 0);

      // Wrap-around: 300 beats of all-ones operands
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(16'hFFFF, 16'hFFFF, (i == 299));
      end
      collect_result("wrap", 24'h57FDA8, 24'hFFFDA8, 16'd300, 0);

      // Asynchronous reset in the middle of a reduction
      apply_stimulus(16'd4, 16'd4, 1'b0);
      apply_stimulus(16'd6, 16'd6, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midreset_out_valid", 32'(u_if.out_valid), 32'd0);
      check_output("midreset_in_ready", 32'(u_if.in_ready), 32'd0);
      check_output("midreset_out_sum", 32'(u_if.out_sum), 32'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check_output("midreset_ready_back", 32'(u_if.in_ready), 32'd1);
      apply_stimulus(16'd1, 16'd1, 1'b1);
      collect_result("after_reset", 24'd2, 24'd2, 16'd1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
